// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the shared ALU and the response consumer.
// Latency: none (wires only); the arbiter drives ready/ALU/response signals.
// Backpressure: rsp_ready from the consumer; r*_ready back to the requesters.
// Optional ALU_ARB_PERF_CNT_EN adds cnt_clr and the two grant counters.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
`ifdef ALU_ARB_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic              r0_valid;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;
  logic [2:0]        r0_op;
  logic              r1_valid;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;
  logic [2:0]        r1_op;
  logic [DATA_W-1:0] alu_srca;
  logic [DATA_W-1:0] alu_srcb;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_id;
  logic              rsp_err;
`ifdef ALU_ARB_PERF_CNT_EN
  logic              cnt_clr;
  logic [CNT_W-1:0]  gnt_cnt0;
  logic [CNT_W-1:0]  gnt_cnt1;
`endif

  // Arbiter side
  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    input  r1_valid, r1_a, r1_b, r1_op,
    output r0_ready, r1_ready,
    output alu_srca, alu_srcb, alu_ctrl,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err,
    input  rsp_ready
`ifdef ALU_ARB_PERF_CNT_EN
    , input  cnt_clr
    , output gnt_cnt0, gnt_cnt1
`endif
  );

  // Environment side: requesters, ALU and consumer
  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    output r1_valid, r1_a, r1_b, r1_op,
    input  r0_ready, r1_ready,
    input  alu_srca, alu_srcb, alu_ctrl,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err,
    output rsp_ready
`ifdef ALU_ARB_PERF_CNT_EN
    , output cnt_clr
    , input  gnt_cnt0, gnt_cnt1
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: 1 cycle from request accept to rsp_valid; 1 op/cycle sustained.
// Backpressure: one-entry response buffer; issue only when empty or draining.
// Optional ALU_ARB_PERF_CNT_EN adds saturating per-requester grant counters.
module alu_arbiter #(
  parameter int DATA_W = 32
`ifdef ALU_ARB_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state;
  logic              last_id;   // requester granted most recently
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              id_q;
  logic              err_q;

  logic              slot_open;
  logic              issue;
  logic              win_id;
  logic [2:0]        win_op;
  logic              op_bad;

  // Slot/winner selection; rst gates readies while reset is held
  always_comb begin
    slot_open = !rst && ((state == EMPTY) || bus.rsp_ready);
    win_id    = bus.r1_valid && (!bus.r0_valid || (last_id == 1'b0));
    issue     = slot_open && (bus.r0_valid || bus.r1_valid);
    win_op    = win_id ? bus.r1_op : bus.r0_op;
    case (win_op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_bad = 1'b0;
      default:                                op_bad = 1'b1;
    endcase
  end

  assign bus.r0_ready = issue && !win_id;
  assign bus.r1_ready = issue &&  win_id;
  assign bus.alu_srca = issue ? (win_id ? bus.r1_a  : bus.r0_a)  : '0;
  assign bus.alu_srcb = issue ? (win_id ? bus.r1_b  : bus.r0_b)  : '0;
  assign bus.alu_ctrl = issue ? win_op : 3'b000;

  // Response buffer and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      last_id <= 1'b1;
      res_q   <= '0;
      zero_q  <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (issue) begin
      state   <= FULL;
      last_id <= win_id;
      res_q   <= bus.alu_result;
      zero_q  <= bus.alu_zero;
      id_q    <= win_id;
      err_q   <= op_bad;
    end else if ((state == FULL) && bus.rsp_ready) begin
      state   <= EMPTY;
    end
  end

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_err    = err_q;

`ifdef ALU_ARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Saturating grant counters; synchronous clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (issue && !win_id && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + 1'b1;
      if (issue &&  win_id && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign bus.gnt_cnt0 = cnt0;
  assign bus.gnt_cnt1 = cnt1;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then random traffic.
// Expected responses are queued at issue and checked by a separate monitor.
// Counter checks are compiled in when ALU_ARB_PERF_CNT_EN is defined.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        id;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;

  alu_arbiter_if #(.DATA_W(DW)
`ifdef ALU_ARB_PERF_CNT_EN
    , .CNT_W(CW)
`endif
  ) bus ();

  alu_arbiter #(.DATA_W(DW)
`ifdef ALU_ARB_PERF_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: 000 and, 001 sub, 010 add, 011 or, 101 xor, others 0
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a - b;
      3'b010:  return a + b;
      3'b011:  return a | b;
      3'b101:  return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic legal_op(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
  endfunction

  assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb);
  assign bus.alu_zero   = (alu_f(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb) == 32'h0);

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  req_t p0, p1;
  bit   m_full;
  bit   m_last;      // requester granted most recently (1 => r0 has priority)
  bit   clr_req;
  int   m_cnt0, m_cnt1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.r0_valid = p0.v; bus.r0_a = p0.a; bus.r0_b = p0.b; bus.r0_op = p0.op;
    bus.r1_valid = p1.v; bus.r1_a = p1.a; bus.r1_b = p1.b; bus.r1_op = p1.op;
`ifdef ALU_ARB_PERF_CNT_EN
    bus.cnt_clr = clr_req;
`endif
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.v  = 1'b1;
    r.a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3));
    r.b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3));
    r.op = 3'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_t r;
    r.v = 1'b1; r.a = a; r.b = b; r.op = op;
    return r;
  endfunction

  // One clock cycle: apply inputs, predict arbitration, check readies, advance model
  task automatic run_cycle(input bit rr);
    bit   slot, issue, w;
    req_t wr;
    exp_t e;
    bus.rsp_ready = rr;
    drive();
    @(negedge clk);
    slot  = !m_full || rr;
    issue = slot && (p0.v || p1.v);
    if (p0.v && p1.v) w = !m_last;
    else              w = p1.v;
    chk("rsp_valid", bus.rsp_valid, m_full);
    chk("r0_ready", bus.r0_ready, issue && !w);
    chk("r1_ready", bus.r1_ready, issue && w);
`ifdef ALU_ARB_PERF_CNT_EN
    chk("gnt_cnt0", bus.gnt_cnt0, m_cnt0);
    chk("gnt_cnt1", bus.gnt_cnt1, m_cnt1);
    if (clr_req) begin
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (issue) begin
      if (!w && m_cnt0 < (1 << CW) - 1) m_cnt0++;
      if ( w && m_cnt1 < (1 << CW) - 1) m_cnt1++;
    end
`endif
    if (issue) begin
      wr     = w ? p1 : p0;
      e.res  = alu_f(wr.op, wr.a, wr.b);
      e.zero = (e.res == 32'h0);
      e.id   = w;
      e.err  = !legal_op(wr.op);
      q.push_back(e);
      m_last = w;
      if (w) p1.v = 1'b0;
      else   p0.v = 1'b0;
    end
    if (issue)   m_full = 1'b1;
    else if (rr) m_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: buffered response must match the queue head; pop on consume
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding request at %0t", $time);
        end else begin
          chk("rsp_result", bus.rsp_result, q[0].res);
          chk("rsp_zero",   bus.rsp_zero,   q[0].zero);
          chk("rsp_id",     bus.rsp_id,     q[0].id);
          chk("rsp_err",    bus.rsp_err,    q[0].err);
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    p0 = '{default: '0};
    p1 = '{default: '0};
    clr_req = 1'b0;
    m_full = 1'b0; m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    bus.rsp_ready = 1'b1;

    // Reset: both requesters valid, nothing may be accepted
    rst = 1'b1;
    p0 = mk_req(32'd1, 32'd2, 3'b010);
    p1 = mk_req(32'd3, 32'd4, 3'b010);
    drive();
    #12;
    chk("rst_r0_ready",  bus.r0_ready,  1'b0);
    chk("rst_r1_ready",  bus.r1_ready,  1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_result", bus.rsp_result, 32'h0);
    chk("rst_rsp_id",    {bus.rsp_zero, bus.rsp_id, bus.rsp_err}, 3'b000);
    p0.v = 1'b0; p1.v = 1'b0;
    drive();
    @(posedge clk); #1;
    rst = 1'b0;

    // 5 - 3 on r0
    p0 = mk_req(32'd5, 32'd3, 3'b001);
    run_cycle(1'b1);
    chk("sub_valid",  bus.rsp_valid,  1'b1);
    chk("sub_result", bus.rsp_result, 32'd2);
    chk("sub_id",     bus.rsp_id,     1'b0);
    run_cycle(1'b1);

    // Both valid every cycle: grants alternate, one response per cycle
    for (int i = 0; i < 6; i++) begin
      if (!p0.v) p0 = rand_req();
      if (!p1.v) p1 = rand_req();
      run_cycle(1'b1);
    end
    for (int i = 0; i < 4; i++) run_cycle(1'b1);

    // Stall: buffer full, consumer not ready, r1 waits then issues on drain
    p0 = mk_req(32'd10, 32'd6, 3'b010);
    run_cycle(1'b0);
    p1 = mk_req(32'd9, 32'd9, 3'b001);
    for (int i = 0; i < 3; i++) run_cycle(1'b0);
    run_cycle(1'b1);
    chk("stall_issue_id",   bus.rsp_id,     1'b1);
    chk("stall_issue_zero", bus.rsp_zero,   1'b1);
    run_cycle(1'b1);

    // Illegal op still captures the ALU's output
    p0 = mk_req(32'd7, 32'd7, 3'b100);
    run_cycle(1'b1);
    chk("bad_err",    bus.rsp_err,    1'b1);
    chk("bad_result", bus.rsp_result, 32'h0);
    chk("bad_zero",   bus.rsp_zero,   1'b1);
    run_cycle(1'b1);

    // Asynchronous reset while full discards the response
    p1 = mk_req(32'd1, 32'd1, 3'b011);
    run_cycle(1'b0);
    p0 = mk_req(32'd8, 32'd2, 3'b000);
    p1 = mk_req(32'd8, 32'd3, 3'b000);
    bus.rsp_ready = 1'b0;
    drive();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.rsp_valid, 1'b0);
    chk("midrst_r0",    bus.r0_ready,  1'b0);
    chk("midrst_r1",    bus.r1_ready,  1'b0);
    rst = 1'b0;
    q.delete();
    m_full = 1'b0; m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    run_cycle(1'b1);
    chk("postrst_id", bus.rsp_id, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1);

`ifdef ALU_ARB_PERF_CNT_EN
    // Saturation at 3, then clear wins over a concurrent grant
    clr_req = 1'b1;
    run_cycle(1'b1);
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p0 = rand_req();
      run_cycle(1'b1);
    end
    chk("cnt0_sat", bus.gnt_cnt0, 2'd3);
    p0 = rand_req();
    clr_req = 1'b1;
    run_cycle(1'b1);
    clr_req = 1'b0;
    chk("cnt0_clr", bus.gnt_cnt0, 2'd0);
    run_cycle(1'b1);
`endif

    // Random traffic with random consumer backpressure
    for (int i = 0; i < 400; i++) begin
      if (!p0.v && $urandom_range(0, 9) < 6) p0 = rand_req();
      if (!p1.v && $urandom_range(0, 9) < 6) p1 = rand_req();
      clr_req = ($urandom_range(0, 19) == 0);
      run_cycle($urandom_range(0, 9) < 7);
    end
    clr_req = 1'b0;

    // Drain everything outstanding
    for (int i = 0; i < 10; i++) begin
      if (!p0.v && !p1.v && !m_full) break;
      run_cycle(1'b1);
    end
    chk("drain_pending", {p0.v, p1.v, m_full}, 3'b000);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
